// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle core controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's ALUOp plus instruction funct fields
// onto the 3-bit ALU operation select.
module multicycle_controller_alu_decoder
  import core_ctrl_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic        op_b5,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi never subtracts.
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset core: sequences fetch/decode/execute
// over the shared datapath and counts retired instructions.
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, next;
  aluop_t alu_op;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_RTYPE:          next = EXECR;
          OP_ITYPE:          next = EXECI;
          OP_BRANCH:         next = BEQ;
          OP_JAL:            next = JAL;
          default:           next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next      = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          next   = FETCH;
          retire = 1'b1;
        end
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        next       = FETCH;
        retire     = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        next      = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        next      = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        next       = FETCH;
        retire     = 1'b1;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
        next      = FETCH;
        retire    = 1'b1;
      end
      // jal writes the target now; the link value PC+4 is written back in ALUWB.
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        next      = ALUWB;
      end
      TRAP:    illegal = 1'b1;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op_b5       (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: random instruction stream with a
// per-instruction event model, plus directed reset, lw-wait and trap sequences.
module tb_multicycle_controller;

  localparam int CNT_W = 32;
  localparam int NPROG = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       op = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7b5 = 1'b0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]       alu_control;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // One observable datapath event: a memory handshake, a register write or a PC write.
  // For register-write events alu reflects the cycle before (the execute step).
  typedef struct packed {
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, src_a, src_b, imm;
    logic        imm_care;
    logic [2:0]  alu;
    logic [31:0] count;
  } ev_t;

  typedef struct {
    int         kind;
    logic [2:0] f3;
    logic       f7;
    logic       z;
  } ins_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;

  ev_t  exp_q[$];
  ins_t prog[$];
  int   checks = 0;
  int   passed = 0;
  int   retired = 0;
  logic mon_en = 1'b0;
  logic hold_prev = 1'b0;
  logic [1:0] hold_sig = '0;
  logic [2:0] alu_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic logic [6:0] opcode_of(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b1110011;
    endcase
  endfunction

  // Operation the ALU must perform for R/I arithmetic: add/sub/slt/or/and codes.
  function automatic logic [2:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b010;
    if (f3 == 3'b111) return 3'b011;
    return 3'b000;
  endfunction

  task automatic push_ev(input logic mr, mw, adr, ir, pcw, rw,
                         input logic [1:0] rs, a, b, imm, input logic care,
                         input logic [2:0] alu);
    ev_t e;
    e = '{mem_req: mr, mem_write: mw, adr_src: adr, ir_write: ir, pc_write: pcw,
          reg_write: rw, result_src: rs, src_a: a, src_b: b, imm: imm,
          imm_care: care, alu: alu, count: retired};
    exp_q.push_back(e);
  endtask

  task automatic push_instr(input ins_t in);
    push_ev(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000);
    case (in.kind)
      K_LW: begin
        push_ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000);
        push_ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000);
        retired++;
      end
      K_SW: begin
        push_ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 3'b000);
        retired++;
      end
      K_R, K_I: begin
        push_ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1,
                alu_ref(in.kind == K_R, in.f3, in.f7));
        retired++;
      end
      K_BEQ: begin
        if (in.z) push_ev(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10, 1, 3'b001);
        retired++;
      end
      K_JAL: begin
        push_ev(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 1, 3'b000);
        push_ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000);
        retired++;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    ev_t e, act;
    if (mon_en && rst_n) begin
      if (hold_prev)
        check("wait_hold", {mem_req, mem_write, adr_src}, {1'b1, hold_sig});
      if ((mem_req && mem_ready) || reg_write || pc_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {mem_req, reg_write, pc_write}, 3'b000);
        end else begin
          e = exp_q.pop_front();
          act = '{mem_req: mem_req, mem_write: mem_write, adr_src: adr_src,
                  ir_write: ir_write, pc_write: pc_write, reg_write: reg_write,
                  result_src: result_src, src_a: alu_src_a, src_b: alu_src_b,
                  imm: e.imm_care ? imm_src : e.imm, imm_care: e.imm_care,
                  alu: reg_write ? alu_prev : alu_control, count: instr_count};
          check("event", 64'(act), 64'(e));
        end
      end
    end
    hold_prev = mem_req && !mem_ready;
    hold_sig  = {mem_write, adr_src};
    alu_prev  = alu_control;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fire;
    int   idx;
    ins_t in;

    for (int i = 0; i < NPROG; i++) begin
      in.kind = int'($urandom_range(0, 5));
      in.f3   = 3'($urandom_range(0, 7));
      in.f7   = 1'($urandom_range(0, 1));
      in.z    = 1'($urandom_range(0, 1));
      prog.push_back(in);
    end
    in.kind = K_BAD; in.f3 = 3'b000; in.f7 = 1'b0; in.z = 1'b0;
    prog.push_back(in);
    foreach (prog[i]) push_instr(prog[i]);

    // Reset state, then IDLE -> FETCH on the first edge after release.
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_count", instr_count, 0);
    check("reset_strobes", {mem_req, ir_write, pc_write, reg_write, illegal}, 5'b0);
    rst_n = 1'b1;
    #1;
    check("idle_outputs", {mem_req, ir_write, pc_write, reg_write, illegal}, 5'b0);
    mon_en = 1'b1;
    step();
    check("first_fetch_req", {mem_req, adr_src, alu_src_b}, {1'b1, 1'b0, 2'b10});

    // Random instruction stream with random memory latency.
    idx = 0;
    for (int cyc = 0; cyc < 6000 && !(idx == prog.size() && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      fire = ir_write;
      step();
      if (fire && idx < prog.size()) begin
        op       = opcode_of(prog[idx].kind);
        funct3   = prog[idx].f3;
        funct7b5 = prog[idx].f7;
        zero     = prog[idx].z;
        idx++;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
    end
    check("random_stream_done", {32'(idx), 32'(exp_q.size())}, {32'(prog.size()), 32'd0});

    // Illegal opcode: DECODE -> TRAP, absorbing, strobes silent, count frozen.
    step();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("trap_state",
            {illegal, mem_req, mem_write, ir_write, pc_write, reg_write,
             result_src, alu_src_a, alu_src_b, instr_count},
            {1'b1, 5'b0, 6'b0, 32'(retired)});
      step();
    end
    mon_en = 1'b0;

    // Directed lw with three wait cycles in MEMREAD.
    rst_n = 1'b0;
    #1;
    check("reset_from_trap", {illegal, instr_count}, 33'd0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    step();
    check("lw_fetch", {mem_req, ir_write, pc_write, adr_src}, 4'b1110);
    step();
    mem_ready = 1'b0;
    check("lw_decode", {alu_src_a, alu_src_b, mem_req}, {2'b01, 2'b01, 1'b0});
    step();
    check("lw_memadr", {alu_src_a, alu_src_b, mem_req}, {2'b10, 2'b01, 1'b0});
    step();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait", {mem_req, adr_src, mem_write, reg_write}, 4'b1100);
      step();
    end
    mem_ready = 1'b1;
    check("lw_ready", {mem_req, adr_src, reg_write}, 3'b110);
    step();
    check("lw_memwb", {result_src, reg_write, mem_req, instr_count}, {2'b01, 1'b1, 1'b0, 32'd0});
    step();
    check("lw_retired", {mem_req, instr_count}, {1'b1, 32'd1});

    // Reset in the middle of a MEMREAD wait drops mem_req without a clock edge.
    step();
    mem_ready = 1'b0;
    step();
    step();
    check("lw2_memread", {mem_req, adr_src}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {mem_req, adr_src, instr_count}, {2'b00, 32'd0});
    #2;
    rst_n = 1'b1;
    check("post_reset_idle", {mem_req, ir_write}, 2'b00);
    step();
    check("post_reset_fetch", {mem_req, adr_src}, 2'b10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
